// File: rtl/block_transfer_seq_if.sv
// Bus bundle for block_transfer_seq: control request, register-file ports and memory handshake.
interface block_transfer_seq_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned LW = 16;

  logic          START;
  logic          L;
  logic          U;
  logic          P;
  logic          W;
  logic [RW-1:0] RN;
  logic [LW-1:0] RLIST;
  logic [AW-1:0] BASE;
  logic [RW-1:0] RS;
  logic [DW-1:0] RDATA;
  logic [RW-1:0] RC;
  logic [DW-1:0] RFD;
  logic          RFLD;
  logic [AW-1:0] MA;
  logic [DW-1:0] MDO;
  logic [DW-1:0] MDI;
  logic          MOE;
  logic          MRW;
  logic          MFC;
  logic          BUSY;
  logic          DONE;

  modport master (
    output START, L, U, P, W, RN, RLIST, BASE, RDATA, MDI, MFC,
    input  RS, RC, RFD, RFLD, MA, MDO, MOE, MRW, BUSY, DONE
  );

  modport slave (
    input  START, L, U, P, W, RN, RLIST, BASE, RDATA, MDI, MFC,
    output RS, RC, RFD, RFLD, MA, MDO, MOE, MRW, BUSY, DONE
  );
endinterface

// File: rtl/block_transfer_seq.sv
// LDM/STM-style block transfer sequencer walking a 16-bit register list in ascending order.
// Define BTS_WRITEBACK_EN to build the base-register writeback (WB) state.
module block_transfer_seq (
  input  logic                 CLK,
  input  logic                 RESET,
  block_transfer_seq_if.slave  bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned NW = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_NEXT  = 3'd2,
    S_XFER  = 3'd3,
    S_LDWR  = 3'd4,
`ifdef BTS_WRITEBACK_EN
    S_WB    = 3'd5,
`endif
    S_FIN   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] mask_q, mask_d, mask_clr;
  logic          l_q, l_d, u_q, u_d, p_q, p_d;
  logic [AW-1:0] base_q, base_d, addr_q, addr_d, four_n;
  logic [NW-1:0] n_q, n_d;
  logic [RW-1:0] cur_q, cur_d, rc_q, rc_d;
  logic [AW-1:0] ma_q, ma_d;
  logic [DW-1:0] mdo_q, mdo_d, rfd_q, rfd_d;
  logic          advance;
`ifdef BTS_WRITEBACK_EN
  logic          w_q, w_d;
  logic [RW-1:0] rn_q, rn_d;
  logic [AW-1:0] final_q, final_d;
`else
  logic          unused_wb;
  assign unused_wb = ^{bus.W, bus.RN};
`endif

  function automatic logic [RW-1:0] lowest_idx(input logic [LW-1:0] m);
    logic [RW-1:0] idx;
    idx = '0;
    for (int i = LW - 1; i >= 0; i--) begin
      if (m[i]) idx = RW'(i);
    end
    return idx;
  endfunction

  function automatic logic [NW-1:0] popcount(input logic [LW-1:0] m);
    logic [NW-1:0] c;
    c = '0;
    for (int i = 0; i < LW; i++) c = c + NW'(m[i]);
    return c;
  endfunction

  assign four_n   = AW'({n_q, 2'b00});
  assign mask_clr = mask_q & ~(LW'(1) << cur_q);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    l_d     = l_q;
    u_d     = u_q;
    p_d     = p_q;
    base_d  = base_q;
    n_d     = n_q;
    addr_d  = addr_q;
    cur_d   = cur_q;
    ma_d    = ma_q;
    mdo_d   = mdo_q;
    rc_d    = rc_q;
    rfd_d   = rfd_q;
    advance = 1'b0;
`ifdef BTS_WRITEBACK_EN
    w_d     = w_q;
    rn_d    = rn_q;
    final_d = final_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          mask_d  = bus.RLIST;
          l_d     = bus.L;
          u_d     = bus.U;
          p_d     = bus.P;
          base_d  = bus.BASE;
          n_d     = popcount(bus.RLIST);
`ifdef BTS_WRITEBACK_EN
          w_d     = bus.W;
          rn_d    = bus.RN;
`endif
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // Lowest register always takes the lowest address of the block.
        unique case ({u_q, p_q})
          2'b10:   addr_d = base_q;
          2'b11:   addr_d = base_q + AW'(4);
          2'b00:   addr_d = base_q - four_n + AW'(4);
          default: addr_d = base_q - four_n;
        endcase
`ifdef BTS_WRITEBACK_EN
        final_d = u_q ? (base_q + four_n) : (base_q - four_n);
`endif
        cur_d   = lowest_idx(mask_q);
        state_d = (mask_q == '0) ? S_FIN : S_NEXT;
      end
      S_NEXT: begin
        ma_d = addr_q;
        if (!l_q) mdo_d = bus.RDATA;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (bus.MFC) begin
          if (l_q) begin
            rfd_d   = bus.MDI;
            rc_d    = cur_q;
            state_d = S_LDWR;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_LDWR: advance = 1'b1;
`ifdef BTS_WRITEBACK_EN
      S_WB:   state_d = S_FIN;
`endif
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Retire the current register and pick the next one (or finish).
    if (advance) begin
      mask_d = mask_clr;
      addr_d = addr_q + AW'(4);
      if (mask_clr != '0) begin
        cur_d   = lowest_idx(mask_clr);
        state_d = S_NEXT;
      end else begin
`ifdef BTS_WRITEBACK_EN
        if (w_q) begin
          rc_d    = rn_q;
          rfd_d   = final_q;
          state_d = S_WB;
        end else begin
          state_d = S_FIN;
        end
`else
        state_d = S_FIN;
`endif
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      l_q     <= 1'b0;
      u_q     <= 1'b0;
      p_q     <= 1'b0;
      base_q  <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      cur_q   <= '0;
      ma_q    <= '0;
      mdo_q   <= '0;
      rc_q    <= '0;
      rfd_q   <= '0;
`ifdef BTS_WRITEBACK_EN
      w_q     <= 1'b0;
      rn_q    <= '0;
      final_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      l_q     <= l_d;
      u_q     <= u_d;
      p_q     <= p_d;
      base_q  <= base_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      cur_q   <= cur_d;
      ma_q    <= ma_d;
      mdo_q   <= mdo_d;
      rc_q    <= rc_d;
      rfd_q   <= rfd_d;
`ifdef BTS_WRITEBACK_EN
      w_q     <= w_d;
      rn_q    <= rn_d;
      final_q <= final_d;
`endif
    end
  end

  // Handshake strobes decode straight from state so reset drops them at once.
  always_comb begin
    bus.MOE  = (state_q == S_XFER);
    bus.MRW  = (state_q == S_XFER) && l_q;
    bus.BUSY = (state_q != S_IDLE);
    bus.DONE = (state_q == S_FIN);
    bus.RFLD = (state_q == S_LDWR);
`ifdef BTS_WRITEBACK_EN
    if (state_q == S_WB) bus.RFLD = 1'b1;
`endif
  end

  assign bus.RS  = cur_q;
  assign bus.RC  = rc_q;
  assign bus.RFD = rfd_q;
  assign bus.MA  = ma_q;
  assign bus.MDO = mdo_q;
endmodule

// File: tb/tb_block_transfer_seq.sv
// Scoreboard bench for block_transfer_seq; expected memory cycles and RF writes are queued
// from a reference model when a transfer is launched and retired as the DUT performs them.
module tb_block_transfer_seq;
  typedef struct packed { logic [31:0] addr; logic rw; logic [31:0] data; } mem_op_t;
  typedef struct packed { logic [3:0] rc; logic [31:0] d; } rf_op_t;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   wait_cfg = 0;
  int   wait_cnt = 0;
  logic moe_prev = 1'b0;
  logic [31:0] ma_hold = '0;
  mem_op_t mem_q[$];
  rf_op_t  rf_q[$];

  block_transfer_seq_if bus();

  block_transfer_seq dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] rf_val(input logic [3:0] r);
    return 32'hA000_0000 | {28'h0, r} | ({28'h0, r} << 16);
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.RDATA = rf_val(bus.RS);
  assign bus.MDI   = mem_val(bus.MA);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder plus scoreboard retirement, sampled on the falling edge.
  always @(negedge clk) begin
    mem_op_t e;
    rf_op_t  r;
    if (bus.MOE === 1'b1) begin
      if (moe_prev) begin
        tests++;
        if (bus.MA !== ma_hold) begin
          fails++;
          $display("FAIL ma_stable: MA=%h was %h", bus.MA, ma_hold);
        end
      end
      ma_hold = bus.MA;
      if (wait_cnt >= wait_cfg) bus.MFC = 1'b1;
      else begin
        bus.MFC = 1'b0;
        wait_cnt++;
      end
      if (bus.MFC) begin
        tests++;
        if (mem_q.size() == 0) begin
          fails++;
          $display("FAIL mem_unexpected: MA=%h MRW=%b", bus.MA, bus.MRW);
        end else begin
          e = mem_q.pop_front();
          if (bus.MA !== e.addr || bus.MRW !== e.rw || (!e.rw && bus.MDO !== e.data)) begin
            fails++;
            $display("FAIL mem_op: MA=%h MRW=%b MDO=%h expected MA=%h MRW=%b MDO=%h",
                     bus.MA, bus.MRW, bus.MDO, e.addr, e.rw, e.data);
          end
        end
      end
    end else begin
      wait_cnt = 0;
      bus.MFC  = (wait_cfg == 0);
    end
    moe_prev = (bus.MOE === 1'b1);
    if (bus.RFLD === 1'b1) begin
      tests++;
      if (rf_q.size() == 0) begin
        fails++;
        $display("FAIL rf_unexpected: RC=%0d RFD=%h", bus.RC, bus.RFD);
      end else begin
        r = rf_q.pop_front();
        if (bus.RC !== r.rc || bus.RFD !== r.d) begin
          fails++;
          $display("FAIL rf_write: RC=%0d RFD=%h expected RC=%0d RFD=%h", bus.RC, bus.RFD, r.rc, r.d);
        end
      end
    end
  end

  // Queue the reference behaviour, launch one transfer and return the DONE cycle (-1 on timeout).
  task automatic run_op(input logic l, input logic u, input logic p, input logic w,
                        input logic [3:0] rn, input logic [15:0] rlist, input logic [31:0] base,
                        input int waits, input int poke_at, output int got);
    int n;
    int k;
    logic [31:0] a;
    logic [31:0] fin;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(rlist[i]);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (rlist[i]) begin
        if (u) a = base + 32'(4 * (k + (p ? 1 : 0)));
        else   a = base - 32'(4 * (n - 1 - k)) - (p ? 32'd4 : 32'd0);
        if (l) begin
          mem_q.push_back('{addr: a, rw: 1'b1, data: 32'h0});
          rf_q.push_back('{rc: 4'(i), d: mem_val(a)});
        end else begin
          mem_q.push_back('{addr: a, rw: 1'b0, data: rf_val(4'(i))});
        end
        k++;
      end
    end
    fin = u ? base + 32'(4 * n) : base - 32'(4 * n);
`ifdef BTS_WRITEBACK_EN
    if (w && n > 0) rf_q.push_back('{rc: rn, d: fin});
`else
    if (w && n > 0) $display("[TB] writeback not built: R%0d keeps its value, final=%h", rn, fin);
`endif
    wait_cfg = waits;
    @(negedge clk);
    bus.L = l; bus.U = u; bus.P = p; bus.W = w; bus.RN = rn;
    bus.RLIST = rlist; bus.BASE = base; bus.START = 1'b1;
    @(posedge clk);
    #1 bus.START = 1'b0;
    got = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == poke_at) begin
        bus.START = 1'b1; bus.RLIST = 16'hFFFF; bus.L = ~l;
      end else begin
        bus.START = 1'b0;
      end
      if (bus.DONE === 1'b1) begin
        got = c;
        break;
      end
    end
    bus.START = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.START = 0; bus.L = 0; bus.U = 0; bus.P = 0; bus.W = 0;
    bus.RN = '0; bus.RLIST = '0; bus.BASE = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.MOE, bus.MRW, bus.RFLD, bus.BUSY, bus.DONE, bus.MA, bus.MDO, bus.RC, bus.RFD, bus.RS} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: MOE=%b RFLD=%b BUSY=%b DONE=%b MA=%h MDO=%h RC=%0d RFD=%h RS=%0d, all required 0",
               bus.MOE, bus.RFLD, bus.BUSY, bus.DONE, bus.MA, bus.MDO, bus.RC, bus.RFD, bus.RS);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_ia();
    int got;
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0005, 32'h0000_1000, 0, -1, got);
    tests++;
    if (got !== 6) begin fails++; $display("FAIL store_ia_done: cycle %0d, expected 6", got); end
    tests++;
    if (mem_q.size() != 0 || rf_q.size() != 0) begin
      fails++; $display("FAIL store_ia_drain: mem left %0d rf left %0d, expected 0 0", mem_q.size(), rf_q.size());
    end
    @(negedge clk);
    tests++;
    if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL store_ia_idle: BUSY=%b expected 0", bus.BUSY); end
  endtask

  task automatic test_load_db_wb();
    int got;
    int exp;
`ifdef BTS_WRITEBACK_EN
    exp = 12;
`else
    exp = 11;
`endif
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 16'h8003, 32'h0000_2000, 0, -1, got);
    tests++;
    if (got !== exp) begin fails++; $display("FAIL load_db_done: cycle %0d, expected %0d", got, exp); end
    tests++;
    if (mem_q.size() != 0 || rf_q.size() != 0) begin
      fails++; $display("FAIL load_db_drain: mem left %0d rf left %0d, expected 0 0", mem_q.size(), rf_q.size());
    end
  endtask

  task automatic test_wait_states();
    int got;
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0005, 32'h0000_1000, 3, -1, got);
    tests++;
    if (got !== 12) begin fails++; $display("FAIL wait_store_done: cycle %0d, expected 12", got); end
    run_op(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0010, 32'h0000_4000, 3, -1, got);
    tests++;
    if (got !== 8) begin fails++; $display("FAIL wait_load_done: cycle %0d, expected 8", got); end
    tests++;
    if (mem_q.size() != 0 || rf_q.size() != 0) begin
      fails++; $display("FAIL wait_drain: mem left %0d rf left %0d, expected 0 0", mem_q.size(), rf_q.size());
    end
  endtask

  task automatic test_empty_list();
    int got;
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0000, 32'h0000_5000, 0, -1, got);
    tests++;
    if (got !== 2) begin fails++; $display("FAIL empty_done: cycle %0d, expected 2", got); end
  endtask

  task automatic test_reset_mid_load();
    int got;
    int rises;
    logic prev;
    logic hit;
    mem_q.push_back('{addr: 32'h0000_3000, rw: 1'b1, data: 32'h0});
    rf_q.push_back('{rc: 4'd0, d: mem_val(32'h0000_3000)});
    wait_cfg = 2;
    @(negedge clk);
    bus.L = 1; bus.U = 1; bus.P = 0; bus.W = 1; bus.RN = 4'd2;
    bus.RLIST = 16'h0007; bus.BASE = 32'h0000_3000; bus.START = 1'b1;
    @(posedge clk);
    #1 bus.START = 1'b0;
    rises = 0; prev = 1'b0; hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.MOE === 1'b1 && !prev) rises++;
      prev = (bus.MOE === 1'b1);
      if (rises == 2) begin hit = 1'b1; break; end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL rst_mid_reach: second XFER seen=%b expected 1", hit); end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({bus.MOE, bus.MRW, bus.RFLD, bus.BUSY, bus.DONE, bus.MA, bus.MDO, bus.RC, bus.RFD, bus.RS} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: MOE=%b RFLD=%b BUSY=%b MA=%h RC=%0d RFD=%h, all required 0",
               bus.MOE, bus.RFLD, bus.BUSY, bus.MA, bus.RC, bus.RFD);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if (mem_q.size() != 0 || rf_q.size() != 0) begin
      fails++; $display("FAIL rst_mid_first: mem left %0d rf left %0d, expected 0 0", mem_q.size(), rf_q.size());
    end
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0006, 32'h0000_6000, 0, -1, got);
    tests++;
    if (got !== 6) begin fails++; $display("FAIL rst_mid_restart: cycle %0d, expected 6", got); end
  endtask

  task automatic test_wrap();
    int got;
    int exp;
`ifdef BTS_WRITEBACK_EN
    exp = 7;
`else
    exp = 6;
`endif
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h0003, 32'hFFFF_FFFC, 0, -1, got);
    tests++;
    if (got !== exp) begin fails++; $display("FAIL wrap_done: cycle %0d, expected %0d", got, exp); end
    tests++;
    if (mem_q.size() != 0 || rf_q.size() != 0) begin
      fails++; $display("FAIL wrap_drain: mem left %0d rf left %0d, expected 0 0", mem_q.size(), rf_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int got;
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0102, 32'h0000_0100, 0, 2, got);
    tests++;
    if (got !== 6) begin fails++; $display("FAIL start_ignored_done: cycle %0d, expected 6", got); end
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'hFFFF, 32'h0000_0000, 1, -1, got);
    tests++;
    if (got !== 66) begin fails++; $display("FAIL full_list_done: cycle %0d, expected 66", got); end
    tests++;
    if (mem_q.size() != 0 || rf_q.size() != 0) begin
      fails++; $display("FAIL b2b_drain: mem left %0d rf left %0d, expected 0 0", mem_q.size(), rf_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_store_ia();
    test_load_db_wb();
    test_wait_states();
    test_empty_list();
    test_reset_mid_load();
    test_wrap();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/block_transfer_seq.md
# block_transfer_seq

Multi-register transfer sequencer for LDM/STM-style block moves. Given a 16-bit register list and a base address, it walks the list in ascending register order. Stores read each register through a register-file read port and drive memory writes. Loads fetch memory words and drive the register-file write port (C address, PC data, RFLD). The block sits between the control unit, the 16×32 register file and the memory handshake (MOE/MFC).

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  begin a transfer; sampled only in IDLE.
- L  in  1  1 = load (memory→RF), 0 = store (RF→memory).
- U  in  1  1 = increment, 0 = decrement.
- P  in  1  1 = pre-index, 0 = post-index.
- W  in  1  base writeback request (see Configuration).
- RN  in  4  base register number, used for writeback.
- RLIST  in  16  register list; bit i selects Ri.
- BASE  in  32  base address value.
- RS  out  4  register-file read address for stores.
- RDATA  in  32  register-file read data for RS.
- RC  out  4  register-file write address.
- RFD  out  32  register-file write data.
- RFLD  out  1  register-file load enable, one-cycle pulses.
- MA  out  32  memory address.
- MDO  out  32  memory write data.
- MDI  in  32  memory read data.
- MOE  out  1  memory operation enable.
- MRW  out  1  1 = read, 0 = write; valid while MOE = 1.
- MFC  in  1  memory function complete.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- Reset: state IDLE, mask = 0. Every output is 0.
- Reset mid-transfer abandons the operation. MOE and RFLD drop asynchronously, and no further RF writes or writeback occur.
- **IDLE**
  - On START = 1, latch RLIST into the pending mask and latch L, U, P, W, RN and BASE.
  - Set n = popcount(RLIST) and go to SETUP.
- **SETUP** (1 cycle)
  - Load the address register with the start address:
    - U=1, P=0: BASE
    - U=1, P=1: BASE+4
    - U=0, P=0: BASE−4n+4
    - U=0, P=1: BASE−4n
  - Load the final address: BASE+4n if U=1, else BASE−4n.
  - Load cur = index of the lowest set bit of the mask.
  - Next state: FIN if the mask is 0, else NEXT.
- **NEXT** (1 cycle): RS = cur. On a store, MDO ← RDATA.
- **XFER**
  - Drive MOE = 1, MRW = L, MA = address register.
  - Hold until MFC is sampled high.
  - Store: clear mask[cur], address += 4, recompute cur, then go to NEXT if the mask is nonzero, else to WB/FIN.
  - Load: RFD ← MDI, RC ← cur, then go to LDWR.
- **LDWR** (1 cycle)
  - Drive RFLD = 1.
  - Clear mask[cur], address += 4, recompute cur.
  - Go to NEXT if the mask is nonzero, else to WB/FIN.
- **WB** (1 cycle): RC = RN, RFD = final address, RFLD = 1. Go to FIN.
- **FIN** (1 cycle): DONE = 1. Go to IDLE.
- Lower-numbered registers always use lower addresses, regardless of U.
- All address arithmetic is 32-bit modulo 2^32. There is no alignment check.
- MFC is ignored outside XFER.
- START is ignored while BUSY.
- If RN is also in the list on a load with writeback, the WB write lands last and wins.
- An empty RLIST gives SETUP→FIN: DONE pulses, with no memory cycles and no writeback.

## Timing
- Cycles below are counted in rising edges after the edge that samples START.
- With MFC already high when MOE rises:
  - a store costs 2 cycles per register;
  - a load costs 3 cycles per register;
  - SETUP, FIN and WB cost 1 cycle each.
- Each MFC wait cycle adds 1 cycle.
- MA, MDO, RC, RFD and RS are registered and hold their last value outside active states.
- MOE, MRW, RFLD, BUSY and DONE are decoded from state.

## Configuration
- BTS_WRITEBACK_EN defined:
  - After the last transfer, if latched W = 1 and n > 0, the block enters WB and writes the final address to RN.
  - If W = 0, it goes straight to FIN.
- BTS_WRITEBACK_EN undefined:
  - The WB state is not built.
  - W and RN are accepted but ignored.
  - The last transfer goes directly to FIN.

## Test plan
- **Store IA.** BASE=0x1000, RLIST=0x0005, L=0, U=1, P=0, MFC tied high.
  - Writes R0 data to MA=0x1000, then R2 data to MA=0x1004.
  - DONE appears on cycle 6.
  - RFLD never asserts.
- **Load DB with writeback** (macro on). BASE=0x2000, RLIST=0x8003, L=1, U=0, P=1, W=1, RN=13.
  - Reads at 0x1FF4, 0x1FF8 and 0x1FFC, writing R0, R1 and R15 in that order.
  - Then writes 0x1FF4 to R13.
  - DONE appears on cycle 12.
- **Wait states.** MFC held low 3 cycles in each XFER.
  - MOE and MA stay stable throughout.
  - Completion is delayed exactly 3 cycles per register.
- **Empty list.** RLIST=0.
  - DONE appears on cycle 2.
  - MOE and RFLD stay 0.
- **Reset mid-load.** Assert RESET during the second XFER.
  - All outputs go to 0 immediately.
  - After release, the block is in IDLE and a new START runs normally.
- **Address wrap.** BASE=0xFFFFFFFC, RLIST=0x0003, U=1, P=0.
  - MA sequence is 0xFFFFFFFC, 0x00000000.
  - With the macro on and W=1, the written-back value is 0x00000004.
